// File: rtl/nubus_memctl_pkg.sv
// ---------------------------------------------------------------------------
// nubus_memctl_pkg
// Shared types and constants for the NuBus / local-processor SRAM controller.
//   state_e : controller FSM states
//   owner_e : which requester owns the access in flight
//   CNT_W   : wait-state down-counter width (covers 0..15 wait states)
// ---------------------------------------------------------------------------
package nubus_memctl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    RECOV  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_NUB = 1'b0,
    OWN_LOC = 1'b1
  } owner_e;

endpackage

// File: rtl/nubus_memctl_arb.sv
// ---------------------------------------------------------------------------
// nubus_memctl_arb
// Two-way grant between the NuBus and local requesters.
// Build option: NUBUS_MEMCTL_RR_EN
//   defined   : round-robin; on a tie the requester not served last wins.
//   undefined : fixed priority, NuBus over local (local may starve).
// Ports:
//   clk_i, rst_n_i   : falling-edge NuBus clock (caller inverts nothing; the
//                      pointer updates on the falling edge), async reset
//   nub_valid_i      : NuBus request pending
//   loc_valid_i      : local request pending
//   take_i           : controller is committing this cycle's grant
//   gnt_any_o        : some requester is pending
//   gnt_owner_o      : winner, meaningful while gnt_any_o
// ---------------------------------------------------------------------------
module nubus_memctl_arb
  import nubus_memctl_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   nub_valid_i,
  input  logic   loc_valid_i,
  input  logic   take_i,
  output logic   gnt_any_o,
  output owner_e gnt_owner_o
);

  assign gnt_any_o = nub_valid_i | loc_valid_i;

`ifdef NUBUS_MEMCTL_RR_EN
  // prio_loc_q holds the preferred side for the next tie: it always points
  // away from whoever was granted last, and resets to prefer NuBus.
  logic prio_loc_q;
  logic prio_loc_d;

  always_comb begin
    gnt_owner_o = OWN_NUB;
    if (nub_valid_i && loc_valid_i) begin
      gnt_owner_o = prio_loc_q ? OWN_LOC : OWN_NUB;
    end else if (loc_valid_i) begin
      gnt_owner_o = OWN_LOC;
    end
  end

  always_comb begin
    prio_loc_d = prio_loc_q;
    if (take_i && gnt_any_o) begin
      prio_loc_d = (gnt_owner_o == OWN_NUB);
    end
  end

  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prio_loc_q <= 1'b0;
    end else begin
      prio_loc_q <= prio_loc_d;
    end
  end
`else
  assign gnt_owner_o = nub_valid_i ? OWN_NUB : OWN_LOC;

  // Fixed priority keeps no history.
  logic unused_arb;
  assign unused_arb = ^{clk_i, rst_n_i, take_i};
`endif

endmodule

// File: rtl/nubus_memctl.sv
// ---------------------------------------------------------------------------
// nubus_memctl
// Serves the NuBus slave memory port and a local processor port from one
// shared synchronous 32-bit SRAM. Arbitrates, sequences each access with
// WAIT_STATES extra cycles, and returns a one-cycle ready per transfer.
// All registers update on the falling edge of nub_clkn.
// Build option: NUBUS_MEMCTL_RR_EN selects round-robin arbitration
// (see nubus_memctl_arb); undefined gives fixed NuBus-over-local priority.
//
// Ports:
//   nub_clkn, nub_resetn             : NuBus clock, async active-low reset
//   nub_valid/addr/wdata/wstrb       : NuBus request (wstrb == 0 is a read)
//   nub_ready, nub_rdata             : NuBus completion pulse and read data
//   loc_valid/addr/wdata/wstrb       : local processor request
//   loc_ready, loc_rdata             : local completion pulse and read data
//   sram_ce, sram_we, sram_addr,
//   sram_wdata                       : SRAM command (ce one cycle per access)
//   sram_rdata                       : SRAM read data, valid one cycle
//                                      after a read ce
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no access; grant on the next edge if anyone is valid
// ACCESS | SRAM access in flight; ce in first cycle, counter runs to 0
// RESP   | owner's ready high for this single cycle
// RECOV  | one dead cycle so a requester can drop valid after ready;
//        | the grant decision is taken on the edge that leaves RECOV
// ---------------------------------------------------------------------------
module nubus_memctl
  import nubus_memctl_pkg::*;
#(
  parameter int ADDR_BITS   = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                 nub_clkn,
  input  logic                 nub_resetn,

  input  logic                 nub_valid,
  input  logic [31:0]          nub_addr,
  input  logic [31:0]          nub_wdata,
  input  logic [3:0]           nub_wstrb,
  output logic                 nub_ready,
  output logic [31:0]          nub_rdata,

  input  logic                 loc_valid,
  input  logic [31:0]          loc_addr,
  input  logic [31:0]          loc_wdata,
  input  logic [3:0]           loc_wstrb,
  output logic                 loc_ready,
  output logic [31:0]          loc_rdata,

  output logic                 sram_ce,
  output logic [3:0]           sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [31:0]          sram_wdata,
  input  logic [31:0]          sram_rdata
);

  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ce_q, ce_d;
  logic [3:0]            we_q, we_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           nub_rdata_q, nub_rdata_d;
  logic [31:0]           loc_rdata_q, loc_rdata_d;
  logic                  nub_ready_q, nub_ready_d;
  logic                  loc_ready_q, loc_ready_d;

  logic                  take;
  logic                  gnt_any;
  owner_e                gnt_owner;
  logic [31:0]           sel_addr;
  logic [31:0]           sel_wdata;
  logic [3:0]            sel_wstrb;

  nubus_memctl_arb u_arb (
    .clk_i       (nub_clkn),
    .rst_n_i     (nub_resetn),
    .nub_valid_i (nub_valid),
    .loc_valid_i (loc_valid),
    .take_i      (take),
    .gnt_any_o   (gnt_any),
    .gnt_owner_o (gnt_owner)
  );

  assign sel_addr  = (gnt_owner == OWN_LOC) ? loc_addr  : nub_addr;
  assign sel_wdata = (gnt_owner == OWN_LOC) ? loc_wdata : nub_wdata;
  assign sel_wstrb = (gnt_owner == OWN_LOC) ? loc_wstrb : nub_wstrb;

  // Byte-lane and aliased high address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{sel_addr[31:ADDR_BITS+2], sel_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    ce_d        = 1'b0;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    nub_rdata_d = nub_rdata_q;
    loc_rdata_d = loc_rdata_q;
    nub_ready_d = 1'b0;
    loc_ready_d = 1'b0;
    take        = 1'b0;

    case (state_q)
      // Leaving RECOV grants directly so back-to-back accesses cost
      // WAIT_STATES+3 cycles; valid is sampled after the dead cycle.
      IDLE, RECOV: begin
        state_d = IDLE;
        if (gnt_any) begin
          take    = 1'b1;
          state_d = ACCESS;
          owner_d = gnt_owner;
          addr_d  = sel_addr[ADDR_BITS+1:2];
          wdata_d = sel_wdata;
          we_d    = sel_wstrb;
          ce_d    = 1'b1;
          cnt_d   = WS_LOAD;
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_NUB) begin
            nub_ready_d = 1'b1;
            if (we_q == 4'h0) nub_rdata_d = sram_rdata;
          end else begin
            loc_ready_d = 1'b1;
            if (we_q == 4'h0) loc_rdata_d = sram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        state_d = RECOV;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NUB;
      cnt_q       <= '0;
      ce_q        <= 1'b0;
      we_q        <= 4'h0;
      addr_q      <= '0;
      wdata_q     <= '0;
      nub_rdata_q <= '0;
      loc_rdata_q <= '0;
      nub_ready_q <= 1'b0;
      loc_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      nub_rdata_q <= nub_rdata_d;
      loc_rdata_q <= loc_rdata_d;
      nub_ready_q <= nub_ready_d;
      loc_ready_q <= loc_ready_d;
    end
  end

  assign sram_ce    = ce_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign nub_ready  = nub_ready_q;
  assign loc_ready  = loc_ready_q;
  assign nub_rdata  = nub_rdata_q;
  assign loc_rdata  = loc_rdata_q;

endmodule

// File: tb/tb_nubus_memctl.sv
// ---------------------------------------------------------------------------
// tb_nubus_memctl
// Directed bench for nubus_memctl. A transaction-level model predicts, from
// the grant edge, when ce and ready must appear and what read data must be
// returned; a compare process checks it every cycle. Literal expectations
// pin the model on the key scenarios. Honors NUBUS_MEMCTL_RR_EN.
// ---------------------------------------------------------------------------
module tb_nubus_memctl;

  localparam int AB = 16;
  localparam int WS = 1;

  logic          nub_clkn   = 1'b1;
  logic          nub_resetn = 1'b0;
  logic          nub_valid  = 1'b0;
  logic [31:0]   nub_addr   = '0;
  logic [31:0]   nub_wdata  = '0;
  logic [3:0]    nub_wstrb  = '0;
  logic          nub_ready;
  logic [31:0]   nub_rdata;
  logic          loc_valid  = 1'b0;
  logic [31:0]   loc_addr   = '0;
  logic [31:0]   loc_wdata  = '0;
  logic [3:0]    loc_wstrb  = '0;
  logic          loc_ready;
  logic [31:0]   loc_rdata;
  logic          sram_ce;
  logic [3:0]    sram_we;
  logic [AB-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;

  always #5 nub_clkn = ~nub_clkn;

  nubus_memctl #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
    .nub_clkn   (nub_clkn),
    .nub_resetn (nub_resetn),
    .nub_valid  (nub_valid),
    .nub_addr   (nub_addr),
    .nub_wdata  (nub_wdata),
    .nub_wstrb  (nub_wstrb),
    .nub_ready  (nub_ready),
    .nub_rdata  (nub_rdata),
    .loc_valid  (loc_valid),
    .loc_addr   (loc_addr),
    .loc_wdata  (loc_wdata),
    .loc_wstrb  (loc_wstrb),
    .loc_ready  (loc_ready),
    .loc_rdata  (loc_rdata),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
  endtask

  // SRAM environment: acts on the rising edge, mid NuBus cycle, so read
  // data is present at the next falling edge and held until the next ce.
  logic [31:0] sram_mem [int];
  always @(posedge nub_clkn) begin
    logic [31:0] w;
    if (sram_ce) begin
      w = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 32'h0;
      if (sram_we == 4'h0) begin
        sram_rdata <= w;
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
        sram_mem[int'(sram_addr)] = w;
      end
    end
  end

  // Transaction model: decisions made on each falling edge from sampled
  // valids; timing derived from the grant edge only.
  logic [31:0] ref_mem [int];
  int          cyc         = 0;
  int          m_free      = 0;
  int          m_ce_cyc    = -1;
  int          m_rdy_cyc   = -1;
  int          m_owner     = 0;
  int          last_served = -1;
  bit          m_read      = 1'b0;
  int          m_word      = 0;
  logic [31:0] m_data      = '0;
  logic [31:0] m_wdata     = '0;
  logic [3:0]  m_we        = '0;

  always @(negedge nub_clkn) begin
    int          win;
    logic [31:0] a, wd, w;
    logic [3:0]  st;
    cyc++;
    if (!nub_resetn) begin
      m_free = 0; m_ce_cyc = -1; m_rdy_cyc = -1; last_served = -1;
    end else if (cyc >= m_free && (nub_valid || loc_valid)) begin
`ifdef NUBUS_MEMCTL_RR_EN
      if (nub_valid && loc_valid) win = (last_served == 0) ? 1 : 0;
`else
      if (nub_valid && loc_valid) win = 0;
`endif
      else win = nub_valid ? 0 : 1;
      a  = win ? loc_addr  : nub_addr;
      wd = win ? loc_wdata : nub_wdata;
      st = win ? loc_wstrb : nub_wstrb;
      m_owner   = win;
      m_ce_cyc  = cyc;
      m_rdy_cyc = cyc + WS + 1;
      m_free    = cyc + WS + 3;
      m_word    = int'(a[AB+1:2]);
      m_we      = st;
      m_wdata   = wd;
      m_read    = (st == 4'h0);
      w = ref_mem.exists(m_word) ? ref_mem[m_word] : 32'h0;
      if (m_read) begin
        m_data = w;
      end else begin
        for (int b = 0; b < 4; b++)
          if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[m_word] = w;
      end
      last_served = win;
    end
  end

  // Per-cycle compare plus event bookkeeping for the literal checks.
  int first_ce_cyc = -1;
  int last_ce_addr = -1;
  int last_ce_we   = -1;
  int nub_rdy_cnt  = 0;
  int last_nub_rdy = -1;
  int order_q [$];

  always @(posedge nub_clkn) begin
    bit e_ce, e_nr, e_lr;
    e_ce = nub_resetn && (cyc == m_ce_cyc);
    e_nr = nub_resetn && (cyc == m_rdy_cyc) && (m_owner == 0);
    e_lr = nub_resetn && (cyc == m_rdy_cyc) && (m_owner == 1);
    chk("sram_ce", {31'b0, sram_ce}, {31'b0, e_ce});
    chk("nub_ready", {31'b0, nub_ready}, {31'b0, e_nr});
    chk("loc_ready", {31'b0, loc_ready}, {31'b0, e_lr});
    chk("ready_exclusive", {31'b0, nub_ready & loc_ready}, 32'h0);
    if (e_ce) begin
      chk("sram_addr", 32'(sram_addr), 32'(m_word));
      chk("sram_we", {28'b0, sram_we}, {28'b0, m_we});
      chk("sram_wdata", sram_wdata, m_wdata);
    end
    if (e_nr && m_read) chk("nub_rdata", nub_rdata, m_data);
    if (e_lr && m_read) chk("loc_rdata", loc_rdata, m_data);
    if (!nub_resetn) begin
      chk("rst_sram_addr", 32'(sram_addr), 32'h0);
      chk("rst_sram_we", {28'b0, sram_we}, 32'h0);
      chk("rst_sram_wdata", sram_wdata, 32'h0);
      chk("rst_nub_rdata", nub_rdata, 32'h0);
      chk("rst_loc_rdata", loc_rdata, 32'h0);
    end
    if (sram_ce) begin
      if (first_ce_cyc < 0) first_ce_cyc = cyc;
      last_ce_addr = int'(sram_addr);
      last_ce_we   = int'(sram_we);
    end
    if (nub_ready) begin
      nub_rdy_cnt++;
      last_nub_rdy = cyc;
      order_q.push_back(0);
    end
    if (loc_ready) order_q.push_back(1);
  end

  // Issue one transfer and wait for its ready. Called at falling edge + 2;
  // returns at falling edge + 2 after the ready cycle.
  task automatic do_xfer(input bit port, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input bit hold,
                         output logic [31:0] rd, output int rc);
    bit got;
    got = 1'b0;
    rd  = '0;
    rc  = -1;
    if (!port) begin
      nub_addr = a; nub_wdata = wd; nub_wstrb = st; nub_valid = 1'b1;
    end else begin
      loc_addr = a; loc_wdata = wd; loc_wstrb = st; loc_valid = 1'b1;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge nub_clkn);
      if (!port ? nub_ready : loc_ready) begin
        got = 1'b1;
        rd  = !port ? nub_rdata : loc_rdata;
        rc  = cyc;
      end
    end
    n_chk++;
    if (got) n_pass++;
    else $display("FAIL xfer_timeout port=%0d addr=%h: got no ready, required ready within 60 cycles", port, a);
    @(negedge nub_clkn); #2;
    if (!hold) begin
      if (!port) nub_valid = 1'b0; else loc_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required finish before 100us");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, rd2;
    int rc, rc2, g, rel, cnt0;
    int exp_order [4];

    // Reset held with both requests pending: compare process checks zeros.
    nub_valid = 1'b1; nub_addr = 32'h20; nub_wstrb = 4'h0;
    loc_valid = 1'b1; loc_addr = 32'h24; loc_wstrb = 4'h0;
    repeat (3) @(negedge nub_clkn);
    #2;
    chk("no_ce_in_reset", 32'(first_ce_cyc), 32'hFFFF_FFFF);
    rel = cyc;
    nub_resetn = 1'b1;
    fork
      do_xfer(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, rc);
      do_xfer(1'b1, 32'h24, 32'h0, 4'h0, 1'b0, rd2, rc2);
    join
    chk("first_grant_edge", 32'(first_ce_cyc), 32'(rel + 1));

    // NuBus word write then read.
    do_xfer(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, rc);
    chk("wr_sram_addr", 32'(last_ce_addr), 32'd4);
    chk("wr_sram_we", 32'(last_ce_we), 32'hF);
    g = cyc + 1;
    do_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, rd, rc);
    chk("rd_word", rd, 32'hDEAD_BEEF);
    chk("rd_latency", 32'(rc - g), 32'd2);

    // Byte write over the word.
    do_xfer(1'b0, 32'h10, 32'h0000_00AA, 4'h1, 1'b0, rd, rc);
    do_xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, rc);
    chk("rd_byte_merge", rd, 32'hDEAD_BEAA);

    // Contention: two transfers per side with valids held across them.
    order_q.delete();
    fork
      begin
        do_xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, rc);
        do_xfer(1'b0, 32'h14, 32'h0, 4'h0, 1'b0, rd, rc);
      end
      begin
        do_xfer(1'b1, 32'h40, 32'h0, 4'h0, 1'b1, rd2, rc2);
        do_xfer(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, rd2, rc2);
      end
    join
`ifdef NUBUS_MEMCTL_RR_EN
    // NuBus was served last before this, so local wins the first tie.
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{0, 0, 1, 1};
`endif
    chk("order_len", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < order_q.size()) chk($sformatf("order_%0d", i), 32'(order_q[i]), 32'(exp_order[i]));
    chk("loc_rd_last", rd2, 32'hDEAD_BEAA);

    // Reset in the second ACCESS cycle of a write (ce already issued).
    nub_addr = 32'h80; nub_wdata = 32'h1234_5678; nub_wstrb = 4'hF; nub_valid = 1'b1;
    @(negedge nub_clkn);
    @(negedge nub_clkn); #2;
    nub_resetn = 1'b0;
    nub_valid  = 1'b0;
    cnt0 = nub_rdy_cnt;
    repeat (2) @(negedge nub_clkn);
    #2;
    nub_resetn = 1'b1;
    chk("midrst_no_ready", 32'(nub_rdy_cnt - cnt0), 32'd0);
    do_xfer(1'b1, 32'h80, 32'h0, 4'h0, 1'b0, rd, rc);
    chk("midrst_committed", rd, 32'h1234_5678);

    // NuBus drops valid during ACCESS; local read queued behind it.
    nub_addr = 32'h90; nub_wdata = 32'hCAFE_F00D; nub_wstrb = 4'hF; nub_valid = 1'b1;
    cnt0 = nub_rdy_cnt;
    @(negedge nub_clkn); #2;
    nub_valid = 1'b0;
    do_xfer(1'b1, 32'h90, 32'h0, 4'h0, 1'b0, rd, rc);
    chk("drop_one_ready", 32'(nub_rdy_cnt - cnt0), 32'd1);
    chk("drop_loc_spacing", 32'(rc - last_nub_rdy), 32'd4);
    chk("drop_loc_data", rd, 32'hCAFE_F00D);

    repeat (3) @(negedge nub_clkn);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
